// File: rtl/rns_pkg.sv
// Shared RNS definitions: default moduli set, residue/word types, FIR control states.
// Optional input residue check is enabled by defining FIR_RNS_RESIDUE_CHECK_EN.
package rns_pkg;
    localparam int DEF_K = 4;
    localparam int DEF_W = 8;

    // Channel 0 is the least significant entry (m0 = 251).
    localparam logic [DEF_K-1:0][31:0] DEFAULT_MODULI = {32'd233, 32'd239, 32'd241, 32'd251};

    typedef logic [DEF_W-1:0]     residue_t;
    typedef residue_t [DEF_K-1:0] rns_word_t;

    typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;
endpackage

// File: rtl/rns_mac_lane.sv
// One residue channel of the FIR datapath: sum = (acc + (coef*x mod M)) mod M.
// Purely combinational; acc and the reduced product are both < M, so one conditional subtract suffices.
module rns_mac_lane #(
    parameter int          W = 8,
    parameter int unsigned M = 251
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] coef,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum
);
    logic [2*W-1:0] prod;
    logic [W-1:0]   prod_m;
    logic [W:0]     s;

    assign prod   = {{W{1'b0}}, coef} * {{W{1'b0}}, x};
    assign prod_m = W'(prod % (2*W)'(M));
    assign s      = {1'b0, acc} + {1'b0, prod_m};
    assign sum    = (s >= (W+1)'(M)) ? W'(s - (W+1)'(M)) : W'(s);
endmodule

// File: rtl/fir_rns_stream.sv
// Streaming N-tap RNS FIR, one tap per cycle across all K channels, valid/ready in and out.
// Define FIR_RNS_RESIDUE_CHECK_EN to flag (in_err) and reduce out-of-range input residues.
module fir_rns_stream
    import rns_pkg::*;
#(
    parameter int                  N      = 16,
    parameter int                  K      = DEF_K,
    parameter int                  W      = DEF_W,
    parameter logic [K-1:0][31:0]  MODULI = DEFAULT_MODULI,
    localparam int                 AW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [K*W-1:0]  coef_data,
    output logic            coef_ready,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [K*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K*W-1:0]  out_data,
    output logic            busy,
    output logic            in_err
);
    typedef logic [K-1:0][W-1:0] word_t;

    fir_state_t     state;
    word_t          coef  [N];
    word_t          dline [N];
    logic [AW-1:0]  head, newest, tap, rd_idx;
    word_t          acc, mac_nxt, x_in;
    logic           accept, coef_hit;

    assign in_ready   = (state == IDLE);
    assign coef_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = (state == IDLE) && !flush && in_valid;
    assign coef_hit   = (state == IDLE) && !flush && coef_we && (32'(coef_addr) < N);

    // Tap i reads the sample i positions behind the newest one, wrapping through the ring.
    always_comb begin
        rd_idx = newest - tap;
        if (newest < tap)
            rd_idx = AW'(N - 32'(tap) + 32'(newest));
    end

`ifdef FIR_RNS_RESIDUE_CHECK_EN
    logic [K-1:0] oor;
`endif

    for (genvar k = 0; k < K; k++) begin : g_lane
        localparam int unsigned M = MODULI[k];

        rns_mac_lane #(.W(W), .M(M)) u_lane (
            .acc  (acc[k]),
            .coef (coef[tap][k]),
            .x    (dline[rd_idx][k]),
            .sum  (mac_nxt[k])
        );

`ifdef FIR_RNS_RESIDUE_CHECK_EN
        assign oor[k]  = 32'(in_data[k*W +: W]) >= M;
        assign x_in[k] = W'(32'(in_data[k*W +: W]) % M);
`else
        assign x_in[k] = in_data[k*W +: W];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            head      <= '0;
            newest    <= '0;
            tap       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int j = 0; j < N; j++) begin
                coef[j]  <= '0;
                dline[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int j = 0; j < N; j++) dline[j] <= '0;
                    end else begin
                        // Write lands before the MAC pass, so a same-cycle sample sees it.
                        if (coef_hit) coef[coef_addr] <= coef_data;
                        if (accept) begin
                            dline[head] <= x_in;
                            newest      <= head;
                            head        <= (head == AW'(N-1)) ? '0 : head + 1'b1;
                            acc         <= '0;
                            tap         <= '0;
                            state       <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc <= mac_nxt;
                    if (tap == AW'(N-1)) begin
                        out_data  <= mac_nxt;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_RNS_RESIDUE_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_err <= 1'b0;
        else        in_err <= accept && (|oor);
    end
`else
    assign in_err = 1'b0;
`endif
endmodule

// File: doc/fir_rns_stream.md
# fir_rns_stream

Streaming, parametrised residue-number-system FIR filter; successor to the fixed 4×8-bit, addressed-buffer RNS FIR. Accepts one RNS-encoded sample per valid/ready handshake, keeps an N-deep circular delay line, and computes y[n] = Σ c[i]·x[n−i] independently per residue channel (mod m_k), one tap per cycle across all channels in parallel. Coefficients are runtime-loadable; output leaves through a valid/ready port. Sits between the binary→RNS forward converter and the RNS→binary reverse converter.

## Interface
- N, 16, number of taps (≥2)
- K, 4, number of residue channels
- W, 8, bits per residue
- MODULI, rns_pkg::DEFAULT_MODULI, K-entry array of moduli, each 2 ≤ m_k ≤ 2^W; channel k occupies bits [k*W +: W]
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(N)  tap index i
- coef_data  in  K*W  RNS coefficient c[i]
- coef_ready  out  1  high when a coefficient write is accepted (state IDLE)
- flush  in  1  clear delay line (IDLE only)
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid&&in_ready
- in_data  in  K*W  RNS sample
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream ready
- out_data  out  K*W  RNS result
- busy  out  1  high in MAC and OUT
- in_err  out  1  one-cycle pulse, out-of-range input residue (macro-dependent)

## Operation
- States: IDLE, MAC, OUT.
- IDLE: in_ready=1, coef_ready=1. Priority: flush > coef_we > sample. flush zeroes delay line in one cycle and suppresses acceptance that cycle. coef_we writes c[coef_addr]; addr ≥ N ignored. Write and sample in same cycle: write first, sample accepted same cycle and uses the new coefficient.
- Accept: sample written at head, head advances (N−1 wraps to 0), accumulators cleared, tap counter i=0, → MAC.
- MAC: for i=0..N−1, per channel acc_k ← (acc_k + (c[i]_k · x[n−i]_k mod m_k)) mod m_k; x[n−i] read at (newest − i) mod N. After i=N−1 → OUT with out_data=acc.
- OUT: out_valid=1, out_data stable; on out_ready → IDLE. in_ready, coef_ready low in MAC/OUT; coef_we, flush ignored there.
- Arithmetic: product 2W bits, sum W+1 bits, both reduced mod m_k; residues assumed < m_k unless checked (see Configuration).
- Reset (any time, including mid-MAC/OUT): state IDLE, delay line, coefficients, accumulators, head, i all zero; out_valid=0, out_data=0, busy=0, in_err=0, in_ready/coef_ready=1 after release.

## Timing
- Accept at edge T; MAC edges T+1..T+N; out_valid high from T+N+1.
- out_ready high at T+N+1 → handshake at T+N+1, next accept possible at T+N+2; max throughput one sample per N+2 cycles.
- out_valid/out_data registered; no combinational path in_*→out_*.
- in_err registered, asserted the cycle after the accepting edge.

## Configuration
- FIR_RNS_RESIDUE_CHECK_EN defined: each accepted residue ≥ m_k raises in_err for one cycle and is stored reduced mod m_k.
- Undefined: no check or reduction; in_err tied 0; out-of-range residues give unspecified results.

## Structure
- rns_pkg: DEFAULT_MODULI (251,241,239,233), W/K defaults, residue and RNS-word typedefs, state enum.
- Sub-module rns_mac_lane: one channel's combinational (acc + c·x mod m) mod m, instantiated K times.

## Test plan
- Impulse: c[i]=i+1 all channels, N=16, input 1 then fifteen 0s → outputs 1,2,…,16 per channel, out_valid at T+17.
- Modular wrap: m0=251, c[0]=250, other taps 0, x=250 → channel 0 output 1.
- Backpressure: out_ready low 5 cycles → out_data stable, in_ready low, in_valid ignored; release → one handshake, IDLE.
- Reset mid-MAC at i=7 → out_valid stays 0, next impulse with reloaded coefficients reproduces impulse results.
- Flush: fill delay line with 3s, flush, impulse → outputs unaffected by previous 3s; coef_we during MAC leaves coefficient unchanged.
- Macro on: channel 0 input 255 (m0=251) → in_err pulse next cycle, residue 4 used.
